// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Parametrised inter-stage pipeline register carrying a DATA_W-bit payload
// between two pipeline stages with a valid/ready handshake. Flush and stall
// controls are included, and a saturating counter records stalled cycles.
//
// With SKID = 1 a second (skid) entry absorbs the beat that arrives while the
// downstream is not ready. ready_o then depends only on local state and on
// flush_i. It never depends on ready_i or stall_i, which breaks the
// combinational ready chain between stages. With SKID = 0 there is a single
// entry and ready_o is a combinational function of the downstream ready.
//
// Ports:
//   clk_i        in   1       clock, all state changes on the rising edge
//   rst_i        in   1       asynchronous reset, active low
//   valid_i      in   1       upstream beat valid
//   data_i       in   DATA_W  upstream payload
//   ready_o      out  1       stage accepts a beat this cycle
//   flush_i      in   1       synchronous kill of held and incoming beats
//   stall_i      in   1       hazard hold, freezes the output beat
//   valid_o      out  1       output beat valid (registered)
//   data_o       out  DATA_W  output payload (registered)
//   ready_i      in   1       downstream accepts
//   stall_cnt_o  out  CNT_W   saturating count of stalled cycles
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int unsigned       DATA_W    = 64,
  parameter bit                SKID      = 1'b1,
  // Bubble payload: all zero except bits [31:26], which form the NOP opcode.
  parameter logic [DATA_W-1:0] FLUSH_VAL = DATA_W'(64'h0000_0000_FC00_0000),
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  input  logic              flush_i,
  input  logic              stall_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              ready_i,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;

  // ---------------------------------------------------------------------------
  // Handshake terms
  // ---------------------------------------------------------------------------
  logic rdy;        // downstream really takes the beat this cycle
  logic ready;      // internal copy of ready_o
  logic accept;     // upstream beat is consumed this cycle
  logic main_free;  // main entry can be overwritten this cycle

  assign rdy       = ready_i & ~stall_i;
  assign main_free = ~main_valid_q | rdy;

  // Flush forces ready so the upstream drops its beat, which is then discarded.
  // With a skid entry, ready is purely registered state (plus flush). This
  // keeps ready_i and stall_i out of the path. Without a skid entry, the stage
  // can only take a beat when the main entry frees up in the same cycle.
  generate
    if (SKID) begin : g_ready_skid
      assign ready = flush_i | ~skid_valid_q;
    end else begin : g_ready_single
      assign ready = flush_i | main_free;
    end
  endgenerate

  assign accept = valid_i & ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every _d signal is given its hold value first, so each path through
  // the if/else tree assigns every signal and no latch is inferred.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;

    if (flush_i) begin
      // Flush beats stall and handshake. Everything held or arriving is dropped.
      main_valid_d = 1'b0;
      main_data_d  = FLUSH_VAL;
      skid_valid_d = 1'b0;
      skid_data_d  = FLUSH_VAL;
    end else if (SKID) begin
      if (main_free) begin
        if (skid_valid_q) begin
          // The older beat waiting in the skid entry goes first to keep FIFO
          // order. ready was low, so no new beat can arrive in this cycle.
          main_valid_d = 1'b1;
          main_data_d  = skid_data_q;
          skid_valid_d = 1'b0;
        end else if (accept) begin
          main_valid_d = 1'b1;
          main_data_d  = data_i;
        end else begin
          main_valid_d = 1'b0;
        end
      end else if (accept) begin
        // Main is held. The skid entry must be empty here, because ready was high.
        skid_valid_d = 1'b1;
        skid_data_d  = data_i;
      end
    end else begin
      if (accept) begin
        // With no skid entry, ready implies main_free, so main can be overwritten.
        main_valid_d = 1'b1;
        main_data_d  = data_i;
      end else if (main_valid_q && rdy) begin
        main_valid_d = 1'b0;
      end
    end
  end

  // Stall counter: counts cycles where a valid beat is held back downstream.
  // It stops at all-ones instead of wrapping to zero.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_valid_q && !rdy && !flush_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: the data registers are reset along with the valid flags, because
  // data_o must show the bubble payload right after reset, not X.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples its pre-edge inputs regardless of statement order.
      main_valid_q <= 1'b0;
      main_data_q  <= FLUSH_VAL;
      skid_valid_q <= 1'b0;
      skid_data_q  <= FLUSH_VAL;
      stall_cnt_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ready_o     = ready;
  assign valid_o     = main_valid_q;
  assign data_o      = main_data_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Three instances share one clock and one reset:
//   dut    SKID=1, CNT_W=16
//   dut_c4 SKID=1, CNT_W=4  (same inputs as dut, shows counter saturation)
//   dut_z  SKID=0, CNT_W=16 (own inputs)
// The reference model treats each stage as a bounded FIFO of beats: capacity 2
// with a skid entry and 1 without. The output shows the head of the FIFO.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam logic [63:0] FV = 64'h0000_0000_FC00_0000;

  logic        clk = 1'b0;
  logic        rst_n;

  // Inputs and outputs shared by dut and dut_c4
  logic        valid_i, flush_i, stall_i, ready_i;
  logic [63:0] data_i;
  logic        ready_o, valid_o;
  logic [63:0] data_o;
  logic [15:0] cnt_o;
  logic        c4_ready, c4_valid;
  logic [63:0] c4_data;
  logic [3:0]  c4_cnt;

  // Inputs and outputs of the SKID=0 instance
  logic        zv, zf, zs, zr;
  logic [63:0] zd;
  logic        z_ready, z_valid;
  logic [63:0] z_data;
  logic [15:0] z_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(64), .SKID(1'b1), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid_i), .data_i(data_i),
    .ready_o(ready_o), .flush_i(flush_i), .stall_i(stall_i),
    .valid_o(valid_o), .data_o(data_o), .ready_i(ready_i),
    .stall_cnt_o(cnt_o));

  pipe_stage_reg #(.DATA_W(64), .SKID(1'b1), .CNT_W(4)) dut_c4 (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid_i), .data_i(data_i),
    .ready_o(c4_ready), .flush_i(flush_i), .stall_i(stall_i),
    .valid_o(c4_valid), .data_o(c4_data), .ready_i(ready_i),
    .stall_cnt_o(c4_cnt));

  pipe_stage_reg #(.DATA_W(64), .SKID(1'b0), .CNT_W(16)) dut_z (
    .clk_i(clk), .rst_i(rst_n), .valid_i(zv), .data_i(zd),
    .ready_o(z_ready), .flush_i(zf), .stall_i(zs),
    .valid_o(z_valid), .data_o(z_data), .ready_i(zr),
    .stall_cnt_o(z_cnt_o));

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [63:0] mq[$];   // beats held by dut (head = output)
  logic [63:0] m_out;   // payload dut should show
  int          m_cnt;   // unsaturated stall count for dut
  logic [63:0] zq[$];
  logic [63:0] z_out;
  int          z_cnt;

  function automatic bit m_ready_exp();
    return flush_i || (mq.size() < 2);
  endfunction

  function automatic bit z_ready_exp();
    return zf || (zq.size() == 0) || (zr && !zs);
  endfunction

  function automatic logic [3:0] c4_exp();
    return (m_cnt > 15) ? 4'd15 : 4'(m_cnt);
  endfunction

  task automatic model_reset();
    mq.delete(); zq.delete();
    m_out = FV;  z_out = FV;
    m_cnt = 0;   z_cnt = 0;
  endtask

  // Advance one clock edge and update the model from the inputs of that cycle.
  task automatic step();
    bit rdy, acc;
    @(posedge clk);
    rdy = ready_i && !stall_i;
    if (flush_i) begin
      mq.delete(); m_out = FV;
    end else begin
      acc = valid_i && (mq.size() < 2);
      if (mq.size() > 0 && !rdy && m_cnt < 65535) m_cnt++;
      if (mq.size() > 0 && rdy) void'(mq.pop_front());
      if (acc) mq.push_back(data_i);
      if (mq.size() > 0) m_out = mq[0];
    end
    rdy = zr && !zs;
    if (zf) begin
      zq.delete(); z_out = FV;
    end else begin
      acc = zv && ((zq.size() == 0) || rdy);
      if (zq.size() > 0 && !rdy && z_cnt < 65535) z_cnt++;
      if (zq.size() > 0 && rdy) void'(zq.pop_front());
      if (acc) zq.push_back(zd);
      if (zq.size() > 0) z_out = zq[0];
    end
    #1;
  endtask

  task automatic drive_m(bit v, logic [63:0] d, bit f, bit s, bit r);
    valid_i = v; data_i = d; flush_i = f; stall_i = s; ready_i = r;
  endtask

  task automatic drive_z(bit v, logic [63:0] d, bit f, bit s, bit r);
    zv = v; zd = d; zf = f; zs = s; zr = r;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    drive_m(0, '0, 0, 0, 0);
    drive_z(0, '0, 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    n_tests++;
    if (valid_o !== 1'b0 || data_o[31:0] !== 32'hFC00_0000 || data_o !== FV ||
        ready_o !== 1'b1 || cnt_o !== 16'd0) begin
      n_fail++;
      $display("FAIL reset skid: valid=%0b data=%h ready=%0b cnt=%0d, want 0 %h 1 0",
               valid_o, data_o, ready_o, cnt_o, FV);
    end
    n_tests++;
    if (z_valid !== 1'b0 || z_data !== FV || z_ready !== 1'b1 || z_cnt_o !== 16'd0 ||
        c4_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL reset single/c4: valid=%0b data=%h ready=%0b cnt=%0d c4=%0d",
               z_valid, z_data, z_ready, z_cnt_o, c4_cnt);
    end
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 4; i++) begin
      drive_m(1, 64'(i), 0, 0, 1);
      #1;
      n_tests++;
      if (ready_o !== 1'b1) begin
        n_fail++;
        $display("FAIL stream ready beat %0d: ready_o=%0b want 1", i, ready_o);
      end
      step();
      n_tests++;
      if (valid_o !== 1'b1 || data_o !== 64'(i)) begin
        n_fail++;
        $display("FAIL stream out beat %0d: valid=%0b data=%h want 1 %h",
                 i, valid_o, data_o, 64'(i));
      end
    end
    drive_m(0, '0, 0, 0, 1);
    step();
    n_tests++;
    if (valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL stream drain: valid_o=%0b want 0", valid_o);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] a = 64'hAAAA_0000_0000_0001;
    logic [63:0] b = 64'hBBBB_0000_0000_0002;
    int base;
    drive_m(1, a, 0, 0, 1);
    step();
    base = m_cnt;
    drive_m(1, b, 0, 0, 0);
    #1;
    step();
    drive_m(0, '0, 0, 0, 0);
    #1;
    n_tests++;
    if (ready_o !== 1'b0 || valid_o !== 1'b1 || data_o !== a) begin
      n_fail++;
      $display("FAIL bp skid full: ready=%0b valid=%0b data=%h want 0 1 %h",
               ready_o, valid_o, data_o, a);
    end
    repeat (2) begin
      step();
      n_tests++;
      if (valid_o !== 1'b1 || data_o !== a) begin
        n_fail++;
        $display("FAIL bp hold: valid=%0b data=%h want 1 %h", valid_o, data_o, a);
      end
    end
    drive_m(0, '0, 0, 0, 1);
    step();
    n_tests++;
    if (valid_o !== 1'b1 || data_o !== b || ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL bp second beat: valid=%0b data=%h ready=%0b want 1 %h 1",
               valid_o, data_o, ready_o, b);
    end
    step();
    n_tests++;
    if (valid_o !== 1'b0 || cnt_o !== 16'(base + 3)) begin
      n_fail++;
      $display("FAIL bp end: valid=%0b cnt=%0d want 0 %0d", valid_o, cnt_o, base + 3);
    end
  endtask

  task automatic test_flush();
    int base;
    drive_m(1, 64'hA1, 0, 0, 1);
    step();
    base = m_cnt;
    drive_m(1, 64'hB2, 0, 0, 0);
    step();
    drive_m(1, 64'hC3, 1, 0, 0);
    #1;
    n_tests++;
    if (ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL flush ready forced: ready_o=%0b want 1", ready_o);
    end
    step();
    drive_m(0, '0, 0, 0, 1);
    #1;
    n_tests++;
    if (valid_o !== 1'b0 || data_o !== FV || ready_o !== 1'b1 || cnt_o !== 16'(base + 1)) begin
      n_fail++;
      $display("FAIL flush result: valid=%0b data=%h ready=%0b cnt=%0d want 0 %h 1 %0d",
               valid_o, data_o, ready_o, cnt_o, FV, base + 1);
    end
    repeat (3) begin
      step();
      n_tests++;
      if (valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL flush leak: valid=%0b data=%h want no beat", valid_o, data_o);
      end
    end
    // Flush together with stall: flush wins and the counter does not move.
    drive_m(1, 64'hD4, 0, 0, 1);
    step();
    base = m_cnt;
    drive_m(1, 64'hE5, 1, 1, 0);
    step();
    n_tests++;
    if (valid_o !== 1'b0 || data_o !== FV || cnt_o !== 16'(base)) begin
      n_fail++;
      $display("FAIL flush+stall: valid=%0b data=%h cnt=%0d want 0 %h %0d",
               valid_o, data_o, cnt_o, FV, base);
    end
  endtask

  task automatic test_stall_hold();
    logic [63:0] x = 64'h1234_5678_9ABC_DEF0;
    logic [63:0] y = 64'h0FED_CBA9_8765_4321;
    int base;
    drive_m(1, x, 0, 0, 1);
    step();
    base = m_cnt;
    drive_m(1, y, 0, 1, 1);  // skid entry may still fill during a stall
    step();
    drive_m(0, '0, 0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++;
      if (valid_o !== 1'b1 || data_o !== x || ready_o !== 1'b0) begin
        n_fail++;
        $display("FAIL stall hold %0d: valid=%0b data=%h ready=%0b want 1 %h 0",
                 i, valid_o, data_o, ready_o, x);
      end
    end
    n_tests++;
    if (cnt_o !== 16'(base + 5)) begin
      n_fail++;
      $display("FAIL stall count: cnt=%0d want %0d", cnt_o, base + 5);
    end
    drive_m(0, '0, 0, 0, 1);
    step();
    n_tests++;
    if (valid_o !== 1'b1 || data_o !== y) begin
      n_fail++;
      $display("FAIL stall release: valid=%0b data=%h want 1 %h", valid_o, data_o, y);
    end
    // 20 more stalled cycles drive the 4-bit counter into saturation.
    drive_m(0, '0, 0, 1, 1);
    repeat (20) step();
    n_tests++;
    if (c4_cnt !== 4'd15 || cnt_o !== 16'(m_cnt)) begin
      n_fail++;
      $display("FAIL stall saturate: c4=%0d cnt=%0d want 15 %0d", c4_cnt, cnt_o, m_cnt);
    end
    drive_m(0, '0, 0, 0, 1);
    step();
  endtask

  task automatic test_reset_mid();
    drive_m(1, 64'h77, 0, 0, 1);
    step();
    drive_m(1, 64'h88, 0, 0, 0);
    step();
    drive_m(0, '0, 0, 0, 0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (valid_o !== 1'b0 || data_o !== FV || ready_o !== 1'b1 || cnt_o !== 16'd0 ||
        c4_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL reset mid: valid=%0b data=%h ready=%0b cnt=%0d c4=%0d want 0 %h 1 0 0",
               valid_o, data_o, ready_o, cnt_o, c4_cnt, FV);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive_m(0, '0, 0, 0, 1);
    step();
    n_tests++;
    if (valid_o !== 1'b0 || data_o !== FV) begin
      n_fail++;
      $display("FAIL reset mid after: valid=%0b data=%h want 0 %h", valid_o, data_o, FV);
    end
  endtask

  task automatic test_single_entry();
    logic [63:0] sb[$];
    logic [63:0] exp_d;
    int accepted = 0;
    int cyc = 0;
    drive_m(0, '0, 0, 0, 1);
    // ready_i toggling with continuous valid: ready_o follows ~valid_o | ready_i.
    for (int i = 0; i < 4; i++) begin
      drive_z(1, 64'(100 + i), 0, 0, (i % 2) == 0);
      #1;
      n_tests++;
      if (z_ready !== ((zq.size() == 0) || zr)) begin
        n_fail++;
        $display("FAIL single toggle %0d: ready_o=%0b want %0b", i, z_ready,
                 (zq.size() == 0) || zr);
      end
      step();
    end
    drive_z(0, '0, 0, 0, 1);
    step();
    // 100 random beats through a scoreboard: no loss, no duplication, in order.
    while (accepted < 100 && cyc < 2000) begin
      drive_z($urandom_range(0, 1), {$urandom, $urandom}, 0, 0, $urandom_range(0, 1));
      #1;
      if (zq.size() > 0 && zr) begin
        exp_d = (sb.size() > 0) ? sb.pop_front() : 64'hX;
        n_tests++;
        if (z_valid !== 1'b1 || z_data !== exp_d) begin
          n_fail++;
          $display("FAIL single scoreboard: valid=%0b data=%h want 1 %h", z_valid, z_data, exp_d);
        end
      end
      if (zv && z_ready_exp()) begin
        sb.push_back(zd);
        accepted++;
      end
      step();
      cyc++;
    end
    n_tests++;
    if (accepted < 100) begin
      n_fail++;
      $display("FAIL single budget: accepted=%0d want 100", accepted);
    end
    drive_z(0, '0, 0, 0, 1);
    #1;
    if (zq.size() > 0) begin
      exp_d = (sb.size() > 0) ? sb.pop_front() : 64'hX;
      n_tests++;
      if (z_valid !== 1'b1 || z_data !== exp_d) begin
        n_fail++;
        $display("FAIL single last beat: valid=%0b data=%h want 1 %h", z_valid, z_data, exp_d);
      end
    end
    step();
    n_tests++;
    if (z_valid !== 1'b0 || sb.size() != 0 || z_cnt_o !== 16'(z_cnt)) begin
      n_fail++;
      $display("FAIL single drain: valid=%0b left=%0d cnt=%0d want 0 0 %0d",
               z_valid, sb.size(), z_cnt_o, z_cnt);
    end
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 400; i++) begin
      drive_m($urandom_range(0, 1), {$urandom, $urandom}, $urandom_range(0, 15) == 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
      drive_z($urandom_range(0, 1), {$urandom, $urandom}, $urandom_range(0, 15) == 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
      #1;
      n_tests++;
      if (ready_o !== m_ready_exp() || z_ready !== z_ready_exp() || c4_ready !== m_ready_exp()) begin
        n_fail++;
        if (errs++ < 10)
          $display("FAIL random ready cyc %0d: skid=%0b single=%0b c4=%0b want %0b %0b",
                   i, ready_o, z_ready, c4_ready, m_ready_exp(), z_ready_exp());
      end
      step();
      n_tests++;
      if (valid_o !== (mq.size() > 0) || data_o !== m_out || cnt_o !== 16'(m_cnt) ||
          c4_valid !== (mq.size() > 0) || c4_data !== m_out || c4_cnt !== c4_exp() ||
          z_valid !== (zq.size() > 0) || z_data !== z_out || z_cnt_o !== 16'(z_cnt)) begin
        n_fail++;
        if (errs++ < 10)
          $display("FAIL random out cyc %0d: v=%0b d=%h c=%0d c4=%0d zv=%0b zd=%h zc=%0d want %0b %h %0d %0d %0b %h %0d",
                   i, valid_o, data_o, cnt_o, c4_cnt, z_valid, z_data, z_cnt_o,
                   mq.size() > 0, m_out, m_cnt, c4_exp(), zq.size() > 0, z_out, z_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_stall_hold();
    test_reset_mid();
    test_single_entry();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
